// File: rtl/rast_pkg.sv
// Shared rasterizer types: iterator state, subsample decode, box indices.
// Used by smpl_iter (optional dual-lane build: SMPL_ITER_MULTI_EN).
package rast_pkg;

  typedef enum logic {
    WAIT_STATE = 1'b0,
    TEST_STATE = 1'b1
  } smpl_iter_state_t;

  localparam int LL = 0;
  localparam int UR = 1;
  localparam int X  = 0;
  localparam int Y  = 1;

  // Anything that is not a clean one-hot rate falls back to 1 spp.
  function automatic logic [1:0] ss_w_lg2_f(input logic [3:0] ss);
    logic [1:0] r;
    case (ss)
      4'b1000: r = 2'd0;
      4'b0100: r = 2'd1;
      4'b0010: r = 2'd2;
      4'b0001: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/smpl_iter_next.sv
// Next lane-A sample in raster order, plus last-sample detect for it.
// MULT is the number of grid steps lane A moves per cycle (1 or 2).
module smpl_iter_next #(
  parameter int SIGFIG = 24,
  parameter int MULT   = 1
) (
  input  logic signed [SIGFIG-1:0] cur_x,
  input  logic signed [SIGFIG-1:0] cur_y,
  input  logic signed [SIGFIG-1:0] step,
  input  logic signed [SIGFIG-1:0] ll_x,
  input  logic signed [SIGFIG-1:0] ur_x,
  input  logic signed [SIGFIG-1:0] ur_y,
  output logic signed [SIGFIG-1:0] nxt_x,
  output logic signed [SIGFIG-1:0] nxt_y,
  output logic                     nxt_last
);

  localparam int SH = (MULT == 2) ? 1 : 0;

  logic signed [SIGFIG-1:0] step_m;
  logic signed [SIGFIG-1:0] cur_adv;
  logic signed [SIGFIG-1:0] nxt_adv;
  logic                     wrap;

  assign step_m  = step <<< SH;
  assign cur_adv = cur_x + step_m;
  assign wrap    = cur_adv > ur_x;
  assign nxt_x   = wrap ? ll_x : cur_adv;
  assign nxt_y   = wrap ? cur_y + step : cur_y;
  assign nxt_adv = nxt_x + step_m;

  // Last when on the top row and no further lane-A step fits.
  assign nxt_last = (nxt_y == ur_y) && (nxt_adv > ur_x);

endmodule

// File: rtl/smpl_iter.sv
// Sample iterator: walks a triangle's bbox grid in raster order.
// Define SMPL_ITER_MULTI_EN for two samples per cycle (lane B).
module smpl_iter
  import rast_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0] color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0] box_R13S,
  input  logic validTri_R13H,
  input  logic [3:0] subSample_RnnnnU,
  output logic halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic [COLORS-1:0][SIGFIG-1:0] color_R16U,
  output logic signed [1:0][SIGFIG-1:0] sample_R16S,
  output logic validSamp_R16H,
  output logic signed [1:0][SIGFIG-1:0] sample_R16S_B,
  output logic validSamp_R16H_B
);

`ifdef SMPL_ITER_MULTI_EN
  localparam int MULT = 2;
`else
  localparam int MULT = 1;
`endif
  localparam int SH = (MULT == 2) ? 1 : 0;

  typedef logic signed [SIGFIG-1:0] coord_t;

  smpl_iter_state_t state_q, state_d;
  logic halt_q, halt_d;
  logic vld_q, vld_d;
  logic signed [1:0][SIGFIG-1:0] samp_q, samp_d;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0] color_q, color_d;
  coord_t llx_q, llx_d;
  coord_t urx_q, urx_d;
  coord_t ury_q, ury_d;
  coord_t step_q, step_d;

  coord_t in_llx, in_lly, in_urx, in_ury;
  coord_t step_in;
  coord_t nxt_x, nxt_y;
  logic   nxt_last;
  logic   acc_last;

  assign in_llx = box_R13S[LL][X];
  assign in_lly = box_R13S[LL][Y];
  assign in_urx = box_R13S[UR][X];
  assign in_ury = box_R13S[UR][Y];

  assign step_in = {{(SIGFIG-1){1'b0}}, 1'b1}
                   << (RADIX - int'(ss_w_lg2_f(subSample_RnnnnU)));

  // Box whose very first emission is already the final one.
  assign acc_last = (in_lly == in_ury)
                 && ((in_llx + (step_in <<< SH)) > in_urx);

  smpl_iter_next #(
    .SIGFIG (SIGFIG),
    .MULT   (MULT)
  ) u_next (
    .cur_x    (coord_t'(samp_q[X])),
    .cur_y    (coord_t'(samp_q[Y])),
    .step     (step_q),
    .ll_x     (llx_q),
    .ur_x     (urx_q),
    .ur_y     (ury_q),
    .nxt_x    (nxt_x),
    .nxt_y    (nxt_y),
    .nxt_last (nxt_last)
  );

`ifdef SMPL_ITER_MULTI_EN
  logic vldb_q, vldb_d;
  logic signed [1:0][SIGFIG-1:0] sampb_q, sampb_d;
  coord_t bx_acc, bx_run;

  assign bx_acc = in_llx + step_in;
  assign bx_run = nxt_x + step_q;
`endif

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    vld_d   = 1'b0;
    samp_d  = samp_q;
    tri_d   = tri_q;
    color_d = color_q;
    llx_d   = llx_q;
    urx_d   = urx_q;
    ury_d   = ury_q;
    step_d  = step_q;
`ifdef SMPL_ITER_MULTI_EN
    vldb_d  = 1'b0;
    sampb_d = sampb_q;
`endif
    unique case (state_q)
      WAIT_STATE: begin
        if (validTri_R13H) begin
          tri_d     = tri_R13S;
          color_d   = color_R13U;
          llx_d     = in_llx;
          urx_d     = in_urx;
          ury_d     = in_ury;
          step_d    = step_in;
          samp_d[X] = in_llx;
          samp_d[Y] = in_lly;
          vld_d     = 1'b1;
          state_d   = acc_last ? WAIT_STATE : TEST_STATE;
          halt_d    = acc_last;
`ifdef SMPL_ITER_MULTI_EN
          sampb_d[X] = bx_acc;
          sampb_d[Y] = in_lly;
          vldb_d     = bx_acc <= in_urx;
`endif
        end
      end
      TEST_STATE: begin
        samp_d[X] = nxt_x;
        samp_d[Y] = nxt_y;
        vld_d     = 1'b1;
        if (nxt_last) begin
          state_d = WAIT_STATE;
          halt_d  = 1'b1;
        end
`ifdef SMPL_ITER_MULTI_EN
        sampb_d[X] = bx_run;
        sampb_d[Y] = nxt_y;
        vldb_d     = bx_run <= urx_q;
`endif
      end
      default: begin
        state_d = WAIT_STATE;
        halt_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_STATE;
      halt_q  <= 1'b1;
      vld_q   <= 1'b0;
      samp_q  <= '0;
      tri_q   <= '0;
      color_q <= '0;
      llx_q   <= '0;
      urx_q   <= '0;
      ury_q   <= '0;
      step_q  <= '0;
`ifdef SMPL_ITER_MULTI_EN
      vldb_q  <= 1'b0;
      sampb_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      vld_q   <= vld_d;
      samp_q  <= samp_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      llx_q   <= llx_d;
      urx_q   <= urx_d;
      ury_q   <= ury_d;
      step_q  <= step_d;
`ifdef SMPL_ITER_MULTI_EN
      vldb_q  <= vldb_d;
      sampb_q <= sampb_d;
`endif
    end
  end

  assign halt_RnnnnL    = halt_q;
  assign validSamp_R16H = vld_q;
  assign sample_R16S    = samp_q;
  assign tri_R16S       = tri_q;
  assign color_R16U     = color_q;

`ifdef SMPL_ITER_MULTI_EN
  assign sample_R16S_B    = sampb_q;
  assign validSamp_R16H_B = vldb_q;
`else
  assign sample_R16S_B    = '0;
  assign validSamp_R16H_B = 1'b0;
`endif

endmodule

// File: doc/smpl_iter.md
# smpl_iter

Sample iterator for the rasterizer pipeline: accepts one bounding-boxed triangle per handshake from the bbox stage and walks every sample-grid point of that box in raster order. It emits one sample per cycle, or two per cycle in the multi-sample configuration. Outputs feed the sample-test stage and the sample-count scoreboard as `tri_R16S` / `color_R16U` / `sample_R16S` / `validSamp_R16H`. The block back-pressures the bbox stage with `halt_RnnnnL` while it is busy with a triangle.

## Interface
Parameters:
- `SIGFIG`, 24: bits in position and color.
- `RADIX`, 10: fraction bits.
- `VERTS`, 3: vertices per triangle.
- `AXIS`, 3: axes per vertex.
- `COLORS`, 3: color channels.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `tri_R13S`, in, [VERTS-1:0][AXIS-1:0] x SIGFIG signed: triangle from bbox.
- `color_R13U`, in, [COLORS-1:0] x SIGFIG: triangle color.
- `box_R13S`, in, [1:0][1:0] x SIGFIG signed: bounding box. Index [0] is lower-left, [1] is upper-right. Inner index [0] is x, [1] is y. Box is inclusive and grid-aligned.
- `validTri_R13H`, in, 1: triangle/box valid.
- `subSample_RnnnnU`, in, 4: one-hot subsample rate.
  - 1000 = 1 sample/pixel
  - 0100 = 4
  - 0010 = 16
  - 0001 = 64
- `halt_RnnnnL`, out, 1: active-low stall to bbox. 0 means hold the current triangle.
- `tri_R16S`, `color_R16U`: out, same shapes as their R13 inputs. Hold the latched triangle.
- `sample_R16S`, out, [1:0] x SIGFIG signed: lane A sample (x, y).
- `validSamp_R16H`, out, 1: lane A valid.
- `sample_R16S_B`, out, [1:0] x SIGFIG signed: lane B sample.
- `validSamp_R16H_B`, out, 1: lane B valid.

## Operation
- Step is `1 << (RADIX - ss_w_lg2)`, with `ss_w_lg2` = 0/1/2/3 for subSample 1000/0100/0010/0001. A non-one-hot `subSample_RnnnnU` uses ss_w_lg2 = 0.
- FSM has two states, `WAIT_STATE` and `TEST_STATE`.
- WAIT_STATE, `validTri_R13H`=1:
  - Latch tri, color, box and step.
  - Drive `sample_R16S` = box LL and `validSamp_R16H`=1.
  - If LL==UR, stay in WAIT_STATE. Otherwise go to TEST_STATE and set halt=0.
- WAIT_STATE, `validTri_R13H`=0: `validSamp_R16H`=0.
- TEST_STATE next-sample rule (lane A):
  - If x+step <= URx, then x += step.
  - Else x = LLx and y += step.
- When the emitted sample is the last one (x, y) = (URx, URy):
  - Go to WAIT_STATE and set halt=1 in that same cycle.
  - If the bbox presents a new triangle that cycle, accept it, so there is no bubble between triangles.
- `validTri_R13H` is ignored in TEST_STATE. The upstream stage holds its triangle while halt=0.
- Arithmetic is signed, SIGFIG wide, with comparisons done as signed. The box is screen-clamped, so no overflow is possible.
- Sample count per triangle is W x H, where W = (URx-LLx)/step + 1 and H = (URy-LLy)/step + 1.
- Reset mid-triangle: the triangle is dropped and all state returns to reset values on the next edge.

## Timing
- Reset values:
  - state = WAIT_STATE
  - `halt_RnnnnL` = 1
  - `validSamp_R16H` = 0, `validSamp_R16H_B` = 0
  - `sample_R16S`, `sample_R16S_B`, `tri_R16S`, `color_R16U` = 0
- All outputs are registered.
- A triangle accepted at edge N gives its first sample valid in cycle N+1.
- `halt_RnnnnL` is low from N+1 through the cycle before the last sample.
- Without `SMPL_ITER_MULTI_EN`, a triangle occupies exactly W x H valid cycles.
- Step and box are latched at acceptance. A `subSample_RnnnnU` change mid-triangle takes effect on the next triangle.

## Configuration
- Macro: `SMPL_ITER_MULTI_EN`.
- Defined:
  - Lane B = (A.x+step, A.y).
  - `validSamp_R16H_B` = `validSamp_R16H` && A.x+step <= URx.
  - Lane A advances 2 steps per cycle. Row wrap occurs when A.x+2*step > URx.
  - Each row takes ceil(W/2) cycles.
  - The last cycle is reached when A.y==URy and A.x+2*step > URx.
- Undefined: lane B outputs are tied to 0 and the single-lane behaviour above applies.

## Structure
- Shared package `rast_pkg` holds:
  - state enum `smpl_iter_state_t` (`WAIT_STATE`, `TEST_STATE`)
  - function `ss_w_lg2_f(subSample)`
  - box index constants `LL`/`UR`/`X`/`Y`
- One sub-module, `smpl_iter_next`: combinational next-sample, row-wrap and last-sample computation, parameterised by lane step multiple (1 or 2).
- The FSM and output registers live in `smpl_iter`.

## Test plan
All scenarios use RADIX=10.
- 1spp, box (0,0)-(2048,1024), single lane:
  - 6 valid cycles in order (0,0), (1024,0), (2048,0), (0,1024), (1024,1024), (2048,1024).
  - halt low in cycles N+1..N+5 and high at N+6.
- 4spp (0100), box (0,0)-(512,512):
  - Step 512, 4 samples.
  - A second triangle held at the input is accepted in the last-sample cycle; its first sample appears the next cycle with no bubble.
- Degenerate box (1024,1024)-(1024,1024): exactly 1 valid cycle, halt stays 1 throughout.
- rst asserted on the 3rd sample of a 6-sample box:
  - Next cycle: all valids 0, halt 1, state WAIT_STATE.
  - A following triangle starts cleanly at its own LL.
- `SMPL_ITER_MULTI_EN`, 1spp, box (0,0)-(2048,1024): 4 cycles.
  - Cycle 1: A=(0,0), B=(1024,0) valid.
  - Cycle 2: A=(2048,0), B invalid.
  - Cycle 3: A=(0,1024), B=(1024,1024) valid.
  - Cycle 4: A=(2048,1024), B invalid.
- Non-one-hot subSample (4'b0110): behaves as 1spp (step 1024).
